inst_prefetch_unit: RTL and testbench
=====================================

Name: inst_prefetch_unit

Overview:
- Instruction fetch front end, directly upstream of the single-cycle core's decode path.
- Replaces the core's direct instruction-memory lookup with a decoupled fetch engine: issues sequential word fetches to instruction memory over a request/response interface and buffers the returned words with their PCs in a small FIFO.
- Presents the buffered words to the core through a valid/ready handshake.
- The core's branch/jump resolution drives a redirect that flushes the buffer and restarts fetch.

Parameters:
- DEPTH, 4, FIFO entries; power of two, at least 2; also the cap on outstanding requests.
- ADDR_W, 32, address/PC width.
- DATA_W, 32, instruction width.
- RESET_PC, 32'h0000_0000, first fetch address after reset.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- mem_req_valid  out  1  fetch request valid.
- mem_req_ready  in  1  memory accepts the request this cycle.
- mem_req_addr  out  ADDR_W  word-aligned fetch address.
- mem_rsp_valid  in  1  response data valid. Responses return in order, one per accepted request, at least 1 cycle after acceptance.
- mem_rsp_data  in  DATA_W  instruction word.
- redirect  in  1  flush and restart fetch (taken branch/jump).
- redirect_addr  in  ADDR_W  new fetch PC.
- inst_valid  out  1  head entry valid.
- inst_ready  in  1  core consumes the head entry.
- inst_data  out  DATA_W  head instruction.
- inst_pc  out  ADDR_W  PC of the head instruction.
- fifo_count  out  $clog2(DEPTH)+1  occupied entries.

Behaviour:
- Reset (rst=0, asynchronous):
  - fetch_pc=RESET_PC, rsp_pc=RESET_PC.
  - FIFO empty, outstanding=0, drop_cnt=0.
  - mem_req_valid=0, inst_valid=0, fifo_count=0, inst_data=0, inst_pc=0.
  - Reset asserted mid-operation discards all state; responses that arrive after release and belong to pre-reset requests are not tracked (memory is reset concurrently).
- Issue:
  - mem_req_valid = !redirect && (fifo_count + outstanding < DEPTH).
  - mem_req_addr = fetch_pc.
  - On accept (valid && ready): fetch_pc += 4, outstanding += 1.
  - fetch_pc changes only on accept or redirect, so the address is stable while waiting.
  - valid may drop without accept only in a redirect cycle; the memory interface permits this.
- Response:
  - mem_rsp_valid decrements outstanding.
  - If drop_cnt>0: the word is discarded and drop_cnt decrements.
  - Otherwise {rsp_pc, data} is pushed and rsp_pc += 4.
  - The credit rule guarantees a push never finds the FIFO full; a push when full is an assertion failure.
- Consume:
  - inst_valid = FIFO not empty; inst_data and inst_pc come from the head entry.
  - Pop on inst_valid && inst_ready.
  - Push and pop in the same cycle leave the count unchanged.
  - First-word latency: a response received in cycle N is visible at the outputs in cycle N+1 (registered FIFO write).
- Redirect (single-cycle pulse, highest priority):
  - FIFO cleared; any pop that cycle is ignored.
  - fetch_pc = rsp_pc = {redirect_addr[ADDR_W-1:2], 2'b00}; low bits are forced to zero.
  - drop_cnt = outstanding_next − (mem_rsp_valid && drop_cnt==0 ? 0 : 0) … rule: drop_cnt_next = outstanding after this cycle's updates. This includes a request accepted in the same cycle (none can be, since valid=0) and excludes a response consumed in the same cycle; that response is itself discarded.
  - Back-to-back redirects: each one recomputes drop_cnt from outstanding.
- Counters:
  - outstanding and drop_cnt are $clog2(DEPTH)+1 bits wide and never exceed DEPTH.
  - fetch_pc wraps modulo 2^ADDR_W.
- Phase FSM (exposed only through the behaviour above):
  - RUN: drop_cnt==0.
  - DRAIN: drop_cnt>0. Issue continues during DRAIN; return to RUN when drop_cnt reaches 0.

Decomposition:
- Shared package:
  - PC_INC=4.
  - The fifo entry struct typedef {pc, instr}.
  - The phase enum {RUN, DRAIN}.
- One sub-module: ifq_fifo, a synchronous DEPTH-entry FIFO with flush, count, and push/pop on the same clk/rst.

Test Plan:
- Reset release, mem_req_ready=1, response latency 2, inst_ready=1 → requests at 0x0, 0x4, 0x8, 0xC; inst_pc sequence 0x0, 0x4, 0x8 with matching data; first inst_valid 3 cycles after the first accept.
- inst_ready=0 held → fifo_count reaches 4; mem_req_valid stays 0 once fifo_count+outstanding=4. Then inst_ready=1 for one cycle → exactly one new request is issued.
- Redirect to 0x100 with 2 requests outstanding → those 2 responses are dropped (never visible); next inst_pc=0x100, then 0x104.
- Redirect with redirect_addr=0x103 in the same cycle as mem_rsp_valid → that response is discarded; mem_req_addr=0x100 the next cycle.
- mem_req_ready=0 for 5 cycles → mem_req_addr held constant, no extra outstanding counted.
- rst pulsed low mid-stream (asynchronous, between edges) → outputs go to reset values immediately; fetch restarts at RESET_PC after release.

Source files
------------

// File: rtl/inst_prefetch_unit_pkg.sv
// Shared definitions for the instruction prefetch unit.
//   PC_INC      : byte distance between sequential instruction words
//   ifq_entry_t : one buffered fetch result {pc, instr} at the default 32/32 widths
//   phase_e     : RUN (every response is kept) / DRAIN (responses are discarded)
package inst_prefetch_unit_pkg;

  localparam int PC_INC     = 4;
  localparam int IFQ_ADDR_W = 32;
  localparam int IFQ_DATA_W = 32;

  typedef struct packed {
    logic [IFQ_ADDR_W-1:0] pc;
    logic [IFQ_DATA_W-1:0] instr;
  } ifq_entry_t;

  typedef enum logic {
    RUN   = 1'b0,
    DRAIN = 1'b1
  } phase_e;

endpackage

// File: rtl/inst_prefetch_unit_ifq_fifo.sv
// Instruction queue FIFO: DEPTH entries of entry_t with flush, push, pop, count.
// Ports:
//   clk, rst        clock, asynchronous active-low reset (pointers/count only)
//   flush           empties the queue; overrides push and pop in the same cycle
//   push/push_entry write one entry at the tail
//   pop             remove the head entry (ignored when empty)
//   head            current head entry (storage content, meaningful when !empty)
//   empty           no entries held
//   count           number of entries held, 0..DEPTH
module inst_prefetch_unit_ifq_fifo
  import inst_prefetch_unit_pkg::*;
#(
  parameter int  DEPTH   = 4,
  parameter type entry_t = ifq_entry_t,
  localparam int PTR_W   = $clog2(DEPTH),
  localparam int CNT_W   = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  entry_t           push_entry,
  input  logic             pop,
  output entry_t           head,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  entry_t           mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             full;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == FULL_CNT);
  assign do_push = push && !flush;
  assign do_pop  = pop && !flush && !empty;
  assign head    = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  // Entry storage carries no reset; only the control above decides validity.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_entry;
  end

  // The fetch credit scheme reserves a slot for every outstanding request,
  // so a push can never meet a full queue.
  a_no_push_when_full: assert property (@(posedge clk) disable iff (!rst) !(do_push && full));

endmodule

// File: rtl/inst_prefetch_unit.sv
// Decoupled instruction fetch front end for the single-cycle core.
// Issues sequential word fetches, buffers {pc, instr} results in a small
// queue and hands them to decode over a valid/ready handshake. A redirect
// from branch resolution flushes the queue and restarts fetch; responses of
// requests issued before the redirect are dropped as they return.
// Ports:
//   clk, rst                          clock, asynchronous active-low reset
//   mem_req_valid/ready/addr          fetch request channel (word aligned)
//   mem_rsp_valid/data                in-order fetch responses
//   redirect, redirect_addr           flush and restart at a new PC
//   inst_valid/ready, inst_data/pc    head of the instruction queue to decode
//   fifo_count                        occupied queue entries
module inst_prefetch_unit
  import inst_prefetch_unit_pkg::*;
#(
  parameter int                DEPTH    = 4,
  parameter int                ADDR_W   = 32,
  parameter int                DATA_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                   clk,
  input  logic                   rst,
  output logic                   mem_req_valid,
  input  logic                   mem_req_ready,
  output logic [ADDR_W-1:0]      mem_req_addr,
  input  logic                   mem_rsp_valid,
  input  logic [DATA_W-1:0]      mem_rsp_data,
  input  logic                   redirect,
  input  logic [ADDR_W-1:0]      redirect_addr,
  output logic                   inst_valid,
  input  logic                   inst_ready,
  output logic [DATA_W-1:0]      inst_data,
  output logic [ADDR_W-1:0]      inst_pc,
  output logic [$clog2(DEPTH):0] fifo_count
);

  localparam int               CNT_W     = $clog2(DEPTH) + 1;
  localparam logic [CNT_W:0]   CREDIT    = (CNT_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] PC_STEP  = ADDR_W'(PC_INC);

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [DATA_W-1:0] instr;
  } entry_t;

  logic [ADDR_W-1:0] fetch_pc;
  logic [ADDR_W-1:0] rsp_pc;
  logic [ADDR_W-1:0] redirect_pc;
  logic [CNT_W-1:0]  outstanding;
  logic [CNT_W-1:0]  outstanding_next;
  logic [CNT_W-1:0]  drop_cnt;
  logic [CNT_W-1:0]  drop_cnt_next;
  logic [CNT_W:0]    credit_used;
  logic              req_fire;
  logic              rsp_push;
  logic              inst_pop;
  logic              fifo_empty;
  logic              redirect_low_unused;
  phase_e            phase;
  phase_e            phase_next;
  entry_t            push_entry;
  entry_t            head;

  // Instructions are word aligned; the low redirect bits carry no information.
  assign redirect_pc         = {redirect_addr[ADDR_W-1:2], 2'b00};
  assign redirect_low_unused = ^redirect_addr[1:0];

  // Every queue slot is either occupied or reserved by an outstanding request.
  assign credit_used   = {1'b0, fifo_count} + {1'b0, outstanding};
  assign mem_req_valid = rst && !redirect && (credit_used < CREDIT);
  assign mem_req_addr  = fetch_pc;
  assign req_fire      = mem_req_valid && mem_req_ready;

  // Outstanding tracks the request just accepted and the response just seen;
  // on redirect, every request still in flight after this cycle must be dropped.
  always_comb begin
    outstanding_next = outstanding + CNT_W'(req_fire) - CNT_W'(mem_rsp_valid);
    drop_cnt_next    = drop_cnt;
    if (redirect) begin
      drop_cnt_next = outstanding_next;
    end else if (mem_rsp_valid && (phase == DRAIN)) begin
      drop_cnt_next = drop_cnt - 1'b1;
    end
  end

  // Phase: RUN keeps responses, DRAIN discards them until drop_cnt is zero.
  // A response arriving in a redirect cycle belongs to the old path.
  always_comb begin
    phase_next = phase;
    rsp_push   = 1'b0;
    case (phase)
      RUN:     rsp_push = mem_rsp_valid && !redirect;
      DRAIN:   rsp_push = 1'b0;
      default: rsp_push = 1'b0;
    endcase
    phase_next = (drop_cnt_next != '0) ? DRAIN : RUN;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      phase <= RUN;
    end else begin
      phase <= phase_next;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc    <= RESET_PC;
      rsp_pc      <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
    end else begin
      outstanding <= outstanding_next;
      drop_cnt    <= drop_cnt_next;
      if (redirect)      fetch_pc <= redirect_pc;
      else if (req_fire) fetch_pc <= fetch_pc + PC_STEP;
      if (redirect)      rsp_pc <= redirect_pc;
      else if (rsp_push) rsp_pc <= rsp_pc + PC_STEP;
    end
  end

  // Response -> queue boundary: the word is registered, visible next cycle.
  assign push_entry = '{pc: rsp_pc, instr: mem_rsp_data};
  assign inst_pop   = inst_valid && inst_ready;

  inst_prefetch_unit_ifq_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (entry_t)
  ) u_ifq_fifo (
    .clk        (clk),
    .rst        (rst),
    .flush      (redirect),
    .push       (rsp_push),
    .push_entry (push_entry),
    .pop        (inst_pop),
    .head       (head),
    .empty      (fifo_empty),
    .count      (fifo_count)
  );

  // Storage is not reset, so the head is masked to zero while the queue is empty.
  assign inst_valid = !fifo_empty;
  assign inst_data  = inst_valid ? head.instr : '0;
  assign inst_pc    = inst_valid ? head.pc    : '0;

endmodule

// File: tb/tb_inst_prefetch_unit.sv
module tb_inst_prefetch_unit;

  localparam int DEPTH  = 4;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic              mem_req_valid;
  logic              mem_req_ready;
  logic [ADDR_W-1:0] mem_req_addr;
  logic              mem_rsp_valid;
  logic [DATA_W-1:0] mem_rsp_data;
  logic              redirect;
  logic [ADDR_W-1:0] redirect_addr;
  logic              inst_valid;
  logic              inst_ready;
  logic [DATA_W-1:0] inst_data;
  logic [ADDR_W-1:0] inst_pc;
  logic [2:0]        fifo_count;

  always #5 clk = ~clk;

  inst_prefetch_unit #(
    .DEPTH    (DEPTH),
    .ADDR_W   (ADDR_W),
    .DATA_W   (DATA_W),
    .RESET_PC (32'h0000_0000)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .mem_req_valid (mem_req_valid),
    .mem_req_ready (mem_req_ready),
    .mem_req_addr  (mem_req_addr),
    .mem_rsp_valid (mem_rsp_valid),
    .mem_rsp_data  (mem_rsp_data),
    .redirect      (redirect),
    .redirect_addr (redirect_addr),
    .inst_valid    (inst_valid),
    .inst_ready    (inst_ready),
    .inst_data     (inst_data),
    .inst_pc       (inst_pc),
    .fifo_count    (fifo_count)
  );

  int          n_total   = 0;
  int          n_pass    = 0;
  int          cyc       = 0;
  int          lat       = 2;
  int          n_acc     = 0;
  int          first_acc = -1;
  int          first_vld = -1;
  logic [31:0] exp_fetch = 32'h0;
  logic [31:0] exp_q[$];     // scoreboard: PCs expected at the decode side, in order
  logic [31:0] mq[$];        // memory model: accepted addresses awaiting response
  int          mdue[$];      // cycle in which each pending response is returned
  logic [31:0] cons_log[$];  // PCs consumed since the last redirect/reset

  function automatic logic [31:0] mkdata(input logic [31:0] a);
    return {~a[15:0], a[15:0]} ^ 32'h5A5A_0000;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic chk_log(input string tag, input int idx, input logic [31:0] exp);
    logic [31:0] obs;
    obs = (idx < cons_log.size()) ? cons_log[idx] : 32'hxxxx_xxxx;
    chk(tag, obs, exp);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_req_valid"}, 32'(mem_req_valid), 32'd0);
    chk({tag, "_inst_valid"}, 32'(inst_valid), 32'd0);
    chk({tag, "_fifo_count"}, 32'(fifo_count), 32'd0);
    chk({tag, "_inst_data"}, inst_data, 32'd0);
    chk({tag, "_inst_pc"}, inst_pc, 32'd0);
  endtask

  // One clock cycle: sample at the falling edge, update the models, then
  // drive the next cycle's inputs 1 time unit after the rising edge.
  task automatic step();
    logic        acc;
    logic        rsp;
    logic        cons;
    logic [31:0] acc_a;
    logic [31:0] e;
    @(negedge clk);
    acc   = mem_req_valid && mem_req_ready;
    acc_a = mem_req_addr;
    rsp   = mem_rsp_valid;
    cons  = inst_valid && inst_ready && !redirect;
    if (inst_valid && first_vld < 0) first_vld = cyc;
    if (cons) begin
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
      chk("inst_pc", inst_pc, e);
      chk("inst_data", inst_data, mkdata(e));
      cons_log.push_back(inst_pc);
    end
    if (acc) begin
      chk("req_addr", acc_a, exp_fetch);
      exp_fetch = exp_fetch + 32'd4;
      n_acc++;
      if (first_acc < 0) first_acc = cyc;
    end
    if (redirect) begin
      exp_q.delete();
      cons_log.delete();
      exp_fetch = {redirect_addr[31:2], 2'b00};
    end
    if (acc) begin
      exp_q.push_back(acc_a);
      mq.push_back(acc_a);
      mdue.push_back(cyc + lat);
    end
    if (rsp && mq.size() > 0) begin
      void'(mq.pop_front());
      void'(mdue.pop_front());
    end
    @(posedge clk);
    #1;
    cyc++;
    redirect = 1'b0;
    if (mq.size() > 0 && mdue[0] <= cyc) begin
      mem_rsp_valid = 1'b1;
      mem_rsp_data  = mkdata(mq[0]);
    end else begin
      mem_rsp_valid = 1'b0;
      mem_rsp_data  = '0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          k;
    int          a0;
    logic [31:0] held;

    rst           = 1'b1;
    mem_req_ready = 1'b1;
    mem_rsp_valid = 1'b0;
    mem_rsp_data  = '0;
    redirect      = 1'b0;
    redirect_addr = '0;
    inst_ready    = 1'b1;
    #1 rst = 1'b0;
    #1;
    chk_reset_outputs("reset");
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;

    // Streaming at latency 2 with decode always ready
    repeat (12) step();
    chk("t1_first_latency", 32'(first_vld - first_acc), 32'd3);
    chk_log("t1_pc0", 0, 32'h0);
    chk_log("t1_pc1", 1, 32'h4);
    chk_log("t1_pc2", 2, 32'h8);

    // Decode stalled: queue fills, credit blocks requests; one pop frees one slot
    inst_ready = 1'b0;
    repeat (12) step();
    chk("t2_fifo_full", 32'(fifo_count), 32'd4);
    chk("t2_req_blocked", 32'(mem_req_valid), 32'd0);
    a0 = n_acc;
    inst_ready = 1'b1;
    step();
    inst_ready = 1'b0;
    repeat (6) step();
    chk("t2_one_refill", 32'(n_acc - a0), 32'd1);
    chk("t2_fifo_full_again", 32'(fifo_count), 32'd4);

    // Redirect with two requests in flight and no response this cycle
    inst_ready = 1'b1;
    lat = 4;
    k = 0;
    while (!(mq.size() == 2 && !mem_rsp_valid) && k < 40) begin
      step();
      k++;
    end
    chk("t3_setup_timeout", 32'(k < 40), 32'd1);
    redirect      = 1'b1;
    redirect_addr = 32'h100;
    step();
    lat = 2;
    repeat (12) step();
    chk_log("t3_pc0", 0, 32'h100);
    chk_log("t3_pc1", 1, 32'h104);

    // Redirect to an unaligned target coinciding with a response
    k = 0;
    while (!mem_rsp_valid && k < 20) begin
      step();
      k++;
    end
    chk("t4_setup_rsp", 32'(mem_rsp_valid), 32'd1);
    redirect      = 1'b1;
    redirect_addr = 32'h103;
    step();
    chk("t4_req_addr", mem_req_addr, 32'h100);
    repeat (12) step();
    chk_log("t4_pc0", 0, 32'h100);
    chk_log("t4_pc1", 1, 32'h104);

    // Memory back-pressure: address held, no phantom outstanding requests
    mem_req_ready = 1'b0;
    held = mem_req_addr;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("t5_addr_hold", mem_req_addr, held);
    end
    mem_req_ready = 1'b1;
    inst_ready    = 1'b0;
    repeat (12) step();
    chk("t5_fifo_full", 32'(fifo_count), 32'd4);
    chk("t5_req_blocked", 32'(mem_req_valid), 32'd0);

    // Asynchronous reset between clock edges mid-stream
    inst_ready = 1'b1;
    repeat (4) step();
    #2 rst = 1'b0;
    #1;
    chk_reset_outputs("t6_async");
    mq.delete();
    mdue.delete();
    exp_q.delete();
    cons_log.delete();
    exp_fetch     = 32'h0;
    mem_rsp_valid = 1'b0;
    mem_rsp_data  = '0;
    repeat (3) step();
    rst = 1'b1;
    repeat (10) step();
    chk_log("t6_pc0", 0, 32'h0);
    chk_log("t6_pc1", 1, 32'h4);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
